// File: rtl/id_regfile_sb.sv
// ID-stage register file: NUM_RD combinational read ports, one WB write port with optional
// write-first bypass, and a per-register pending-write scoreboard that drives per-port busy flags.
module id_regfile_sb #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 4,
  parameter int                NUM_RD      = 3,
  parameter bit                WRITE_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_dest,
  output logic                       iss_full,
  input  logic                       flush
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] reg_vals [NREG];
  logic [1:0]        cnt_vals [NREG];

  logic inc;
  logic dec;

  // Outputs are gated with rst so a write strobe held during reset cannot leak through the bypass.
  assign iss_full = rst && iss_en && (cnt_vals[iss_dest] == 2'd3);
  assign inc      = iss_en && !iss_full && !flush;
  assign dec      = wr_en && (cnt_vals[wr_addr] != 2'd0);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [DATA_W-1:0] data_q;
      logic [DATA_W-1:0] data_d;
      logic [1:0]        cnt_q;
      logic [1:0]        cnt_d;
      logic              wr_hit;
      logic              inc_hit;
      logic              dec_hit;

      assign wr_hit  = wr_en && (wr_addr == ADDR_W'(gi));
      assign inc_hit = inc && (iss_dest == ADDR_W'(gi));
      assign dec_hit = dec && (wr_addr == ADDR_W'(gi));

      always_comb begin
        data_d = data_q;
        if (wr_hit) begin
          data_d = wr_data;
        end
      end

      // Issue and retire on the same register cancel; guards on inc/dec keep this in 0..3.
      always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
          cnt_d = 2'd0;
        end else if (inc_hit && !dec_hit) begin
          cnt_d = cnt_q + 2'd1;
        end else if (dec_hit && !inc_hit) begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q <= RESET_VAL;
          cnt_q  <= 2'd0;
        end else begin
          data_q <= data_d;
          cnt_q  <= cnt_d;
        end
      end

      assign reg_vals[gi] = data_q;
      assign cnt_vals[gi] = cnt_q;
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] idx;
      logic [1:0]        cnt;
      logic              byp;

      assign idx = rd_addr[gi*ADDR_W +: ADDR_W];
      assign cnt = cnt_vals[idx];
      assign byp = WRITE_FIRST && rst && wr_en && (wr_addr == idx);

      assign rd_data[gi*DATA_W +: DATA_W] = byp ? wr_data : reg_vals[idx];
      // The last outstanding write landing this cycle is already visible via the bypass.
      assign rd_busy[gi] = rst && (cnt != 2'd0) && !(byp && (cnt == 2'd1));
    end
  endgenerate

endmodule
